// File: rtl/vga_pkg.sv
// Shared VGA-side definitions for the sprite fetch stage.
// Holds the visible raster size, default coordinate/colour widths and the
// position-update FSM state encoding.
package vga_pkg;

    localparam int unsigned H_ACTIVE        = 640;
    localparam int unsigned V_ACTIVE        = 480;
    localparam int unsigned VGA_COORD_WIDTH = 10;
    localparam int unsigned RGB_WIDTH       = 24;

    // Sprite position update FSM: idle, shadow holds an uncommitted update,
    // shadow is being copied to the active position.
    typedef enum logic [1:0] {
        POS_IDLE    = 2'd0,
        POS_PENDING = 2'd1,
        POS_COMMIT  = 2'd2
    } pos_state_e;

endpackage

// File: rtl/delay_line.sv
// Parameterised shift register with synchronous active-high reset.
// Ports:
//   clk, rst   rising-edge clock, synchronous reset (clears every stage)
//   din        value entering the line
//   dout       din delayed by DEPTH clocks (DEPTH >= 1)
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; reset empties the whole line at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sprite_fetch.sv
// Sprite fetch stage: hit-tests the raster position against one rectangular
// sprite, reads the texel from a synchronous sprite ROM and emits it aligned
// with a delayed display-enable, ready for the colour generator.
// Sprite position updates are double-buffered and only committed at frame
// start (hcount == 0, vcount == 0) so a frame never shows two positions.
//
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   bright_in       display-active flag from the timing stage
//   hcount, vcount  raster column / row
//   pos_x, pos_y    requested sprite top-left corner, captured by pos_load
//   pos_load        one-cycle strobe capturing the requested position
//   mirror_h        (SPRITE_FETCH_MIRROR_EN only) horizontal mirror request,
//                   captured and committed together with the position
//   rom_addr        sprite ROM read address (registered)
//   rom_data        sprite ROM read data
//   bright          bright_in delayed to line up with pixel
//   pix_en          sprite covers this pixel
//   pixel           texel, 0 when pix_en is 0
//   pos_busy        a captured position is waiting for frame start
//
// Timing: inputs to outputs take 1+ROM_LATENCY clocks. The rom_addr register
// is the first of the ROM_LATENCY read stages, so rom_data must carry the
// texel for rom_addr ROM_LATENCY-1 clocks after rom_addr changes.
//
// Optional build macro: SPRITE_FETCH_MIRROR_EN adds the mirror_h input.
module sprite_fetch
    import vga_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = RGB_WIDTH,
    parameter int unsigned COORD_WIDTH = VGA_COORD_WIDTH,
    parameter int unsigned SPRITE_W    = 64,
    parameter int unsigned SPRITE_H    = 64,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bright_in,
    input  logic [COORD_WIDTH-1:0] hcount,
    input  logic [COORD_WIDTH-1:0] vcount,
    input  logic [COORD_WIDTH-1:0] pos_x,
    input  logic [COORD_WIDTH-1:0] pos_y,
    input  logic                   pos_load,
`ifdef SPRITE_FETCH_MIRROR_EN
    input  logic                   mirror_h,
`endif
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    output logic                   bright,
    output logic                   pix_en,
    output logic [DATA_WIDTH-1:0]  pixel,
    output logic                   pos_busy
);

    localparam int unsigned DIFF_W = COORD_WIDTH + 1;
    localparam int unsigned COL_W  = $clog2(SPRITE_W);

    pos_state_e state, next_state;

    logic [COORD_WIDTH-1:0] act_x, act_y;
    logic [COORD_WIDTH-1:0] shd_x, shd_y;
`ifdef SPRITE_FETCH_MIRROR_EN
    logic                   act_mirror, shd_mirror;
`endif

    logic [DIFF_W-1:0]     dx, dy;
    logic [COL_W-1:0]      col;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic                  hit_c;
    logic                  frame_start_c;
    logic                  shadow_we_c;
    logic                  commit_c;
    logic [1:0]            align_q;

    // Offsets carry one extra bit so a sprite near the right/bottom edge
    // shows up as a negative offset at low raster positions, not a wrapped hit.
    assign dx = {1'b0, hcount} - {1'b0, act_x};
    assign dy = {1'b0, vcount} - {1'b0, act_y};

    assign hit_c = bright_in
                 && !dx[DIFF_W-1] && !dy[DIFF_W-1]
                 && (dx < DIFF_W'(SPRITE_W))
                 && (dy < DIFF_W'(SPRITE_H));

    // SPRITE_W is a power of two, so SPRITE_W-1-dx is the bitwise inverse.
`ifdef SPRITE_FETCH_MIRROR_EN
    assign col = act_mirror ? ~dx[COL_W-1:0] : dx[COL_W-1:0];
`else
    assign col = dx[COL_W-1:0];
`endif

    // dy*SPRITE_W + col as a concatenation.
    assign addr_c = ADDR_WIDTH'({dy, col});

    assign frame_start_c = (hcount == '0) && (vcount == '0);

    // Stage 1: ROM address, held between hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
        end else if (hit_c) begin
            rom_addr <= addr_c;
        end
    end

    // Carry bright_in and hit alongside the ROM read.
    delay_line #(
        .WIDTH(2),
        .DEPTH(ROM_LATENCY)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  ({bright_in, hit_c}),
        .dout (align_q)
    );

    // Output stage: texel captured only for covered pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            bright <= 1'b0;
            pix_en <= 1'b0;
            pixel  <= '0;
        end else begin
            bright <= align_q[1];
            pix_en <= align_q[0];
            pixel  <= align_q[0] ? rom_data : '0;
        end
    end

    // Position FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= POS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Position FSM: next state. A load coinciding with frame start in
    // PENDING still commits; the shadow is rewritten on that same edge so
    // the commit uses the newest request.
    always_comb begin
        next_state = state;
        case (state)
            POS_IDLE: begin
                if (pos_load) begin
                    next_state = POS_PENDING;
                end
            end
            POS_PENDING: begin
                if (frame_start_c) begin
                    next_state = POS_COMMIT;
                end
            end
            POS_COMMIT: begin
                next_state = pos_load ? POS_PENDING : POS_IDLE;
            end
            default: begin
                next_state = POS_IDLE;
            end
        endcase
    end

    // Position FSM: outputs. Every state accepts a load into the shadow.
    always_comb begin
        shadow_we_c = 1'b0;
        commit_c    = 1'b0;
        case (state)
            POS_IDLE:    shadow_we_c = pos_load;
            POS_PENDING: shadow_we_c = pos_load;
            POS_COMMIT: begin
                shadow_we_c = pos_load;
                commit_c    = 1'b1;
            end
            default:     shadow_we_c = 1'b0;
        endcase
    end

    // Shadow and active position registers plus the busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_x    <= '0;
            shd_y    <= '0;
            act_x    <= '0;
            act_y    <= '0;
            pos_busy <= 1'b0;
`ifdef SPRITE_FETCH_MIRROR_EN
            shd_mirror <= 1'b0;
            act_mirror <= 1'b0;
`endif
        end else begin
            if (shadow_we_c) begin
                shd_x <= pos_x;
                shd_y <= pos_y;
`ifdef SPRITE_FETCH_MIRROR_EN
                shd_mirror <= mirror_h;
`endif
            end
            if (commit_c) begin
                act_x <= shd_x;
                act_y <= shd_y;
`ifdef SPRITE_FETCH_MIRROR_EN
                act_mirror <= shd_mirror;
`endif
            end
            pos_busy <= (next_state == POS_PENDING);
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: directed scenarios plus a randomized
// stream compared against a behavioural model of the sprite rules.
module tb_sprite_fetch;

    localparam int unsigned DW = 24;
    localparam int unsigned CW = 10;
    localparam int unsigned AW = 12;
    localparam int          SW = 64;
    localparam int          SH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          bright_in;
    logic [CW-1:0] hcount, vcount, pos_x, pos_y;
    logic          pos_load;
`ifdef SPRITE_FETCH_MIRROR_EN
    logic          mirror_h;
`endif
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          bright, pix_en, pos_busy;
    logic [DW-1:0] pixel;

    logic [DW-1:0] rom_mem [1 << AW];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int m_ax, m_ay, m_sx, m_sy;
    bit m_am, m_sm;
    bit m_wait, m_commit;
    bit m_prev_hit, m_prev_bright;
    int m_addr_reg;

    // Expected outputs after the most recent clock.
    int            e_addr;
    bit            e_bright, e_pix_en, e_busy;
    logic [DW-1:0] e_pixel;

    always #5 clk = ~clk;

    // Single-cycle ROM read on the registered address.
    assign rom_data = rom_mem[rom_addr];

    sprite_fetch #(
        .DATA_WIDTH (DW),
        .COORD_WIDTH(CW),
        .SPRITE_W   (SW),
        .SPRITE_H   (SH),
        .ADDR_WIDTH (AW),
        .ROM_LATENCY(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bright_in(bright_in),
        .hcount   (hcount),
        .vcount   (vcount),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .pos_load (pos_load),
`ifdef SPRITE_FETCH_MIRROR_EN
        .mirror_h (mirror_h),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .bright   (bright),
        .pix_en   (pix_en),
        .pixel    (pixel),
        .pos_busy (pos_busy)
    );

    // Drive one cycle of inputs, clock it, and advance the model.
    task automatic step(input int hc, input int vc, input bit b, input bit ld,
                        input int px, input int py, input bit mir, input bit r);
        int dx, dy, col, cur_addr;
        bit hit, fs, nxt_wait, nxt_commit;
        hcount    = CW'(hc);
        vcount    = CW'(vc);
        bright_in = b;
        pos_load  = ld;
        pos_x     = CW'(px);
        pos_y     = CW'(py);
        rst       = r;
`ifdef SPRITE_FETCH_MIRROR_EN
        mirror_h  = mir;
`endif
        dx  = hc - m_ax;
        dy  = vc - m_ay;
        hit = b && (dx >= 0) && (dx < SW) && (dy >= 0) && (dy < SH);
        col = m_am ? (SW - 1 - dx) : dx;
        cur_addr = (dy * SW + col) % (1 << AW);
        fs  = (hc == 0) && (vc == 0);
        @(posedge clk);
        #1;
        if (r) begin
            m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0; m_am = 0; m_sm = 0;
            m_wait = 0; m_commit = 0; m_prev_hit = 0; m_prev_bright = 0;
            m_addr_reg = 0;
            e_addr = 0; e_bright = 0; e_pix_en = 0; e_pixel = '0; e_busy = 0;
        end else begin
            e_bright = m_prev_bright;
            e_pix_en = m_prev_hit;
            e_pixel  = m_prev_hit ? rom_mem[m_addr_reg] : '0;
            if (hit) m_addr_reg = cur_addr;
            e_addr        = m_addr_reg;
            m_prev_hit    = hit;
            m_prev_bright = b;
            if (m_commit) begin
                m_ax = m_sx; m_ay = m_sy; m_am = m_sm;
            end
            nxt_commit = m_wait && fs;
            nxt_wait   = (m_wait && !fs) || (!m_wait && ld);
            if (ld) begin
                m_sx = px; m_sy = py;
`ifdef SPRITE_FETCH_MIRROR_EN
                m_sm = mir;
`else
                m_sm = 1'b0;
`endif
            end
            m_commit = nxt_commit;
            m_wait   = nxt_wait;
            e_busy   = m_wait;
        end
    endtask

    // Request a position and run through frame start so it becomes active.
    task automatic load_pos(input int x, input int y, input bit mir);
        step(10, 300, 0, 1, x, y, mir, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(10, 10, 1, 1, 100, 50, 0, 0);
        step(20, 20, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b1 || pos_busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset pix_en=%b pos_busy=%b want 1 1", pix_en, pos_busy);
        end
        step(30, 30, 1, 1, 5, 5, 0, 1);
        n_cmp++;
        if (bright !== 1'b0 || pix_en !== 1'b0 || pixel !== '0 || pos_busy !== 1'b0
            || rom_addr !== '0) begin
            n_err++;
            $display("FAIL reset_outputs bright=%b pix_en=%b pixel=%h busy=%b addr=%0d want all 0",
                     bright, pix_en, pixel, pos_busy, rom_addr);
        end
        step(31, 30, 1, 0, 0, 0, 0, 1);
        step(32, 30, 1, 0, 0, 0, 0, 1);
        // Pending position discarded: sprite still at (0,0) and not busy.
        step(3, 3, 1, 0, 0, 0, 0, 0);
        step(200, 200, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b1 || pos_busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_pos pix_en=%b busy=%b want 1 0", pix_en, pos_busy);
        end
    endtask

    task automatic test_basic_hit();
        load_pos(100, 50, 0);
        step(101, 50, 1, 0, 0, 0, 0, 0);
        step(100, 50, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rom_addr !== 12'd0) begin
            n_err++;
            $display("FAIL basic_addr got=%0d want=0", rom_addr);
        end
        step(5, 5, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b1 || bright !== 1'b1 || pixel !== 24'hAA5500) begin
            n_err++;
            $display("FAIL basic_pixel pix_en=%b bright=%b pixel=%h want 1 1 aa5500",
                     pix_en, bright, pixel);
        end
    endtask

    task automatic test_clip();
        step(163, 113, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rom_addr !== 12'd4095) begin
            n_err++;
            $display("FAIL clip_corner_addr got=%0d want=4095", rom_addr);
        end
        step(164, 113, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b1 || pixel !== rom_mem[4095] || rom_addr !== 12'd4095) begin
            n_err++;
            $display("FAIL clip_corner_pix pix_en=%b pixel=%h addr=%0d want 1 %h 4095",
                     pix_en, pixel, rom_addr, rom_mem[4095]);
        end
        step(99, 50, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b0 || pixel !== '0 || bright !== 1'b1) begin
            n_err++;
            $display("FAIL clip_right pix_en=%b pixel=%h bright=%b want 0 0 1", pix_en, pixel, bright);
        end
        step(5, 5, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b0 || pixel !== '0) begin
            n_err++;
            $display("FAIL clip_left pix_en=%b pixel=%h want 0 0", pix_en, pixel);
        end
        load_pos(1000, 0, 0);
        step(5, 0, 1, 0, 0, 0, 0, 0);
        step(6, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b0 || pixel !== '0) begin
            n_err++;
            $display("FAIL no_wrap pix_en=%b pixel=%h want 0 0", pix_en, pixel);
        end
        step(1010, 20, 1, 0, 0, 0, 0, 0);
        step(7, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b1 || pixel !== rom_mem[20*64+10]) begin
            n_err++;
            $display("FAIL edge_clip_hit pix_en=%b pixel=%h want 1 %h", pix_en, pixel, rom_mem[20*64+10]);
        end
    endtask

    task automatic test_blank();
        load_pos(100, 50, 0);
        step(110, 60, 0, 0, 0, 0, 0, 0);
        step(5, 5, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b0 || bright !== 1'b0 || pixel !== '0) begin
            n_err++;
            $display("FAIL blank pix_en=%b bright=%b pixel=%h want 0 0 0", pix_en, bright, pixel);
        end
    endtask

    task automatic test_deferred();
        step(10, 240, 1, 1, 200, 10, 0, 0);
        n_cmp++;
        if (pos_busy !== 1'b1) begin
            n_err++;
            $display("FAIL defer_busy got=%b want=1", pos_busy);
        end
        step(100, 50, 1, 0, 0, 0, 0, 0);
        step(5, 5, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b1) begin
            n_err++;
            $display("FAIL defer_old_pos pix_en=%b want=1", pix_en);
        end
        step(20, 300, 0, 1, 300, 20, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pos_busy !== 1'b0) begin
            n_err++;
            $display("FAIL defer_busy_drop got=%b want=0", pos_busy);
        end
        step(300, 20, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rom_addr !== 12'd0) begin
            n_err++;
            $display("FAIL defer_new_addr got=%0d want=0", rom_addr);
        end
        step(200, 10, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b1) begin
            n_err++;
            $display("FAIL defer_new_hit pix_en=%b want=1", pix_en);
        end
        step(5, 5, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pix_en !== 1'b0) begin
            n_err++;
            $display("FAIL defer_first_pos_gone pix_en=%b want=0", pix_en);
        end
    endtask

`ifdef SPRITE_FETCH_MIRROR_EN
    task automatic test_mirror();
        load_pos(0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rom_addr !== 12'd63) begin
            n_err++;
            $display("FAIL mirror_addr got=%0d want=63", rom_addr);
        end
        step(5, 5, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pixel !== rom_mem[63]) begin
            n_err++;
            $display("FAIL mirror_pixel got=%h want=%h", pixel, rom_mem[63]);
        end
        load_pos(0, 0, 0);
    endtask
`endif

    task automatic test_random();
        int hc, vc, px, py;
        bit r, ld, b, mir;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r   = ($urandom_range(0, 599) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            b   = ($urandom_range(0, 9) != 0);
            mir = $urandom_range(0, 1) == 1;
            px  = $urandom_range(0, 1023);
            py  = $urandom_range(0, 500);
            if ($urandom_range(0, 59) == 0) begin
                hc = 0; vc = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                hc = (m_ax + $urandom_range(0, 72) - 4 + 1024) % 1024;
                vc = (m_ay + $urandom_range(0, 72) - 4 + 1024) % 1024;
            end else begin
                hc = $urandom_range(0, 1023);
                vc = $urandom_range(0, 1023);
            end
            step(hc, vc, b, ld, px, py, mir, r);
            n_cmp++;
            if (rom_addr !== AW'(e_addr)) begin
                n_err++;
                $display("FAIL rand_addr cyc=%0d got=%0d want=%0d", cyc, rom_addr, e_addr);
            end
            n_cmp++;
            if (pix_en !== e_pix_en) begin
                n_err++;
                $display("FAIL rand_pix_en cyc=%0d got=%b want=%b", cyc, pix_en, e_pix_en);
            end
            n_cmp++;
            if (pixel !== e_pixel) begin
                n_err++;
                $display("FAIL rand_pixel cyc=%0d got=%h want=%h", cyc, pixel, e_pixel);
            end
            n_cmp++;
            if (bright !== e_bright) begin
                n_err++;
                $display("FAIL rand_bright cyc=%0d got=%b want=%b", cyc, bright, e_bright);
            end
            n_cmp++;
            if (pos_busy !== e_busy) begin
                n_err++;
                $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, pos_busy, e_busy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            rom_mem[i] = DW'($urandom);
        end
        rom_mem[0] = 24'hAA5500;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        test_reset();
        test_basic_hit();
        test_clip();
        test_blank();
        load_pos(100, 50, 0);
        test_deferred();
`ifdef SPRITE_FETCH_MIRROR_EN
        test_mirror();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
